// File: rtl/dram_result_transmitter.sv
// dram_result_transmitter
//   Streams a fixed window of DRAM (START_ADDR .. START_ADDR+NUM_BYTES-1) to
//   the PC as UART 8N1 once processing is finished and the transmit button
//   is held. Each byte is fetched (FETCH, WAIT), then framed as
//   start / 8 data bits LSB first / stop, each bit CLKS_PER_BIT cycles long.
//
// Ports
//   clk              : system clock (single domain)
//   rst              : synchronous active-high reset
//   begin_transmit   : debounced button level, starts a transfer from IDLE
//   dm_out[7:0]      : DRAM read data (registered read, 2 edges after addr)
//   addr_com[15:0]   : DRAM read address
//   en_com           : this block owns the DRAM address port
//   data_to_pc       : UART TX line, idle high
//   busy             : transfer in progress (not IDLE / DONE)
//   end_transmitting : high while in DONE
//
// Every output is a flop; the next value of each is derived from the next
// state, so outputs line up with the state register without any
// combinational path from inputs.
module dram_result_transmitter #(
   parameter int          CLKS_PER_BIT = 16,
   parameter logic [15:0] START_ADDR   = 16'h0000,
   parameter logic [15:0] NUM_BYTES    = 16'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        begin_transmit,
   input  logic [7:0]  dm_out,
   output logic [15:0] addr_com,
   output logic        en_com,
   output logic        data_to_pc,
   output logic        busy,
   output logic        end_transmitting
);

   localparam int             BW       = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_STOP, S_DONE
   } state_t;

   state_t        state, state_n;
   logic [BW-1:0] baud_cnt, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shreg, shreg_n;
   logic [15:0]   byte_cnt, byte_n;
   logic [15:0]   addr_n;
   logic          data_n, own_n, end_n;
   logic          baud_last;

   assign baud_last = (baud_cnt == BAUD_MAX);

   // next-state and datapath updates
   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_idx;
      shreg_n = shreg;
      byte_n  = byte_cnt;
      addr_n  = addr_com;
      case (state)
         S_IDLE: begin
            if (begin_transmit) begin
               byte_n  = 16'd0;
               addr_n  = START_ADDR;
               state_n = S_FETCH;
            end
         end
         // address has been presented since entering FETCH; DRAM q is
         // valid by the edge that closes WAIT
         S_FETCH: state_n = S_WAIT;
         S_WAIT: begin
            shreg_n = dm_out;
            baud_n  = '0;
            state_n = S_START;
         end
         S_START: begin
            if (baud_last) begin
               baud_n  = '0;
               bit_n   = 3'd0;
               state_n = S_DATA;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_n  = '0;
               shreg_n = {1'b0, shreg[7:1]};
               bit_n   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = S_STOP;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_n  = '0;
               byte_n  = byte_cnt + 16'd1;
               addr_n  = addr_com + 16'd1;
               state_n = ((byte_cnt + 16'd1) == NUM_BYTES) ? S_DONE : S_FETCH;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         S_DONE: begin
            // wait for release so a held button cannot retrigger
            if (!begin_transmit) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // registered output values for the state being entered
   always_comb begin
      data_n = 1'b1;
      own_n  = 1'b0;
      end_n  = 1'b0;
      case (state_n)
         S_FETCH, S_WAIT: own_n = 1'b1;
         S_START: begin own_n = 1'b1; data_n = 1'b0;       end
         S_DATA:  begin own_n = 1'b1; data_n = shreg_n[0]; end
         S_STOP:  own_n = 1'b1;
         S_DONE:  end_n = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         baud_cnt         <= '0;
         bit_idx          <= 3'd0;
         shreg            <= 8'd0;
         byte_cnt         <= 16'd0;
         addr_com         <= START_ADDR;
         en_com           <= 1'b0;
         busy             <= 1'b0;
         data_to_pc       <= 1'b1;
         end_transmitting <= 1'b0;
      end else begin
         state            <= state_n;
         baud_cnt         <= baud_n;
         bit_idx          <= bit_n;
         shreg            <= shreg_n;
         byte_cnt         <= byte_n;
         addr_com         <= addr_n;
         en_com           <= own_n;
         busy             <= own_n;
         data_to_pc       <= data_n;
         end_transmitting <= end_n;
      end
   end

endmodule

// File: tb/tb_dram_result_transmitter.sv
// Self-checking bench for dram_result_transmitter: cycle-by-cycle comparison
// against a frame-timing model plus an independent UART receiver.
module tb_dram_result_transmitter;

   localparam int          CPB = 4;
   localparam logic [15:0] SA  = 16'h0010;
   localparam int          NB  = 3;
   localparam int          P   = 2 + 10 * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic        begin_transmit;
   logic [7:0]  dm_out;
   logic [15:0] addr_com;
   logic        en_com, data_to_pc, busy, end_transmitting;

   logic [7:0]  mem [0:65535];
   logic [7:0]  rxq [$];
   int          n_chk = 0;
   int          n_fail = 0;

   dram_result_transmitter #(.CLKS_PER_BIT(CPB), .START_ADDR(SA), .NUM_BYTES(16'(NB))) dut (
      .clk(clk), .rst(rst), .begin_transmit(begin_transmit), .dm_out(dm_out),
      .addr_com(addr_com), .en_com(en_com), .data_to_pc(data_to_pc),
      .busy(busy), .end_transmitting(end_transmitting)
   );

   always #5 clk = ~clk;

   // DRAM with registered read
   always @(posedge clk) dm_out <= mem[addr_com];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // UART receiver: mid-bit sampling after a falling start edge
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (data_to_pc === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = data_to_pc;
            end
            repeat (CPB) @(negedge clk);
            if (data_to_pc === 1'b1) rxq.push_back(b);
         end
      end
   end

   // expected {end, busy, en, line, addr} k edges after the start press
   function automatic logic [19:0] model(input int k);
      int i, p, s;
      logic line;
      logic [15:0] a;
      if (k > NB * P) return {1'b1, 1'b0, 1'b0, 1'b1, 16'(SA + NB)};
      i = (k - 1) / P;
      p = (k - 1) % P;
      a = 16'(SA + i);
      if (p < 2) line = 1'b1;
      else begin
         s = (p - 2) / CPB;
         if (s == 0)      line = 1'b0;
         else if (s <= 8) line = mem[a][s-1];
         else             line = 1'b1;
      end
      return {1'b0, 1'b1, 1'b1, line, a};
   endfunction

   task automatic run_transfer(input int hold, input bit drop);
      @(negedge clk);
      begin_transmit = 1'b1;
      rxq.delete();
      for (int k = 1; k <= NB * P + 1; k++) begin
         @(posedge clk); #1;
         chk($sformatf("cyc%0d", k), {end_transmitting, busy, en_com, data_to_pc, addr_com}, model(k));
         // first cycle of byte 1's stop bit
         if (drop && k == 3 + 9 * CPB) begin_transmit = 1'b0;
      end
      if (!drop) begin
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("held", {end_transmitting, busy, en_com, data_to_pc}, 4'b1001);
         end
         @(negedge clk);
         begin_transmit = 1'b0;
      end
      @(posedge clk); #1;
      chk("to_idle", {end_transmitting, busy, en_com, data_to_pc}, 4'b0001);
      chk("rx_cnt", rxq.size(), NB);
      for (int i = 0; i < NB; i++)
         chk($sformatf("rx_byte%0d", i), (rxq.size() > i) ? rxq[i] : 8'hxx, mem[16'(SA + i)]);
   endtask

   task automatic abort_transfer();
      @(negedge clk);
      begin_transmit = 1'b1;
      // land inside the data bits of byte 2
      repeat (P + 2 + 3 * CPB + 1) @(posedge clk);
      #1;
      chk("abort_pre", {busy, en_com}, 2'b11);
      @(negedge clk);
      rst = 1'b1;
      begin_transmit = 1'b0;
      @(posedge clk); #1;
      chk("abort_rst", {end_transmitting, busy, en_com, data_to_pc, addr_com},
          {1'b0, 1'b0, 1'b0, 1'b1, SA});
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("abort_quiet", {end_transmitting, busy, data_to_pc}, 3'b001);
   endtask

   initial begin
      rst = 1'b1;
      begin_transmit = 1'b1;
      for (int r = 0; r < 2; r++) begin
         @(posedge clk); #1;
         chk("reset", {end_transmitting, busy, en_com, data_to_pc, addr_com},
             {1'b0, 1'b0, 1'b0, 1'b1, SA});
      end
      @(negedge clk);
      rst = 1'b0;
      begin_transmit = 1'b0;
      @(posedge clk); #1;
      chk("idle", {end_transmitting, busy, en_com, data_to_pc}, 4'b0001);

      mem[16'h0010] = 8'h01; mem[16'h0011] = 8'hFF; mem[16'h0012] = 8'h80;
      run_transfer(500, 1'b0);
      run_transfer(3, 1'b0);

      mem[16'h0010] = 8'hA5;
      mem[16'h0011] = 8'($urandom);
      mem[16'h0012] = 8'($urandom);
      run_transfer(0, 1'b1);

      abort_transfer();
      run_transfer(2, 1'b0);

      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < NB; i++) mem[16'(SA + i)] = 8'($urandom);
         run_transfer(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
